// File: rtl/sga_pkg.sv
// Shared Snake Game Arcade definitions: matrix geometry, scan states and frame bit layout.
package sga_pkg;

  localparam int unsigned SGA_ROWS = 6;
  localparam int unsigned SGA_COLS = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BLANK = 2'b01,
    ST_DRIVE = 2'b10,
    ST_NEXT  = 2'b11
  } scan_state_e;

  // Frame bit of (row, col): rows are packed low-first, cols bits per row.
  function automatic int unsigned frame_bit(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/frame_double_buffer.sv
// Shadow/active frame pair: strobes land in shadow, commits publish shadow to active.
module frame_double_buffer #(
  parameter int unsigned FW = 36
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [FW-1:0] frame_i,
  input  logic          commit_i,
  output logic [FW-1:0] active_o,
  output logic          pending_o
);

  logic [FW-1:0] shadow_q, shadow_d;
  logic [FW-1:0] active_q, active_d;
  logic          pending_q, pending_d;

  // A load in the commit cycle wins pending back: the new frame waits for the next boundary.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (commit_i) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load_i) begin
      shadow_d  = frame_i;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign active_o  = active_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix scan driver with blanking between rows and
// tear-free frame updates committed only on frame boundaries.
module led_matrix_scanner
  import sga_pkg::*;
#(
  parameter int unsigned ROWS         = SGA_ROWS,
  parameter int unsigned COLS         = SGA_COLS,
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic                     clock,
  input  logic                     restart,
  input  logic                     enable,
  input  logic [ROWS*COLS-1:0]     frame,
  input  logic                     frame_valid,
  output logic [ROWS-1:0]          row_sel,
  output logic [COLS-1:0]          col_data,
  output logic                     frame_done,
  output logic [$clog2(ROWS)-1:0]  db_row,
  output logic [1:0]               db_state
);

  localparam int unsigned FW      = ROWS * COLS;
  localparam int unsigned RW      = $clog2(ROWS);
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  scan_state_e     state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ROWS-1:0] row_sel_q, row_sel_d;
  logic [COLS-1:0] col_data_q, col_data_d;
  logic            frame_done_q, frame_done_d;

  logic [FW-1:0]   active;
  logic            pending;
  logic            last_row;
  logic            commit;

  assign last_row = (row_q == RW'(ROWS - 1));
  assign commit   = pending && ((state_q == ST_IDLE) || ((state_q == ST_NEXT) && last_row));

  frame_double_buffer #(
    .FW(FW)
  ) u_buf (
    .clk_i    (clock),
    .rst_i    (restart),
    .load_i   (frame_valid),
    .frame_i  (frame),
    .commit_i (commit),
    .active_o (active),
    .pending_o(pending)
  );

  // Next scan position, then outputs derived from where the scan is heading.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    row_sel_d    = '0;
    col_data_d   = '0;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        row_d = '0;
        cnt_d = '0;
        if (enable) state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_IDLE;
          row_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRIVE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          row_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
          state_d = ST_NEXT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_NEXT: begin
        cnt_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
        if (enable) begin
          state_d = ST_BLANK;
        end else begin
          state_d = ST_IDLE;
          row_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Active never changes on an edge entering DRIVE, so the current copy is the one shown.
    if (state_d == ST_DRIVE) begin
      row_sel_d  = ROWS'(1) << row_d;
      col_data_d = active[frame_bit(32'(row_d), 0, COLS) +: COLS];
    end
    frame_done_d = (state_d == ST_NEXT) && (row_d == RW'(ROWS - 1));
  end

  always_ff @(posedge clock) begin
    if (restart) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      cnt_q        <= '0;
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      row_sel_q    <= row_sel_d;
      col_data_q   <= col_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_sel    = row_sel_q;
  assign col_data   = col_data_q;
  assign frame_done = frame_done_q;
  assign db_row     = row_q;
  assign db_state   = state_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner: directed scenarios plus random traffic
// against a time-position model of the scan (tick count since scan start).
module tb_led_matrix_scanner;

  localparam int ROWS = 6;
  localparam int COLS = 6;
  localparam int DW   = 4;
  localparam int BW   = 1;
  localparam int RP   = BW + DW + 1;
  localparam int FP   = ROWS * RP;
  localparam int FW   = ROWS * COLS;

  logic            clock = 1'b0;
  logic            restart = 1'b1;
  logic            enable = 1'b0;
  logic            frame_valid = 1'b0;
  logic [FW-1:0]   frame = '0;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_data;
  logic            frame_done;
  logic [2:0]      db_row;
  logic [1:0]      db_state;
  logic [17:0]     obs;

  int n_run  = 0;
  int n_fail = 0;

  // Model: scanning flag, edges since the scan left IDLE, and the two frame buffers.
  bit            m_scan    = 1'b0;
  int            m_tick    = 0;
  logic [FW-1:0] m_active  = '0;
  logic [FW-1:0] m_shadow  = '0;
  bit            m_pending = 1'b0;

  always #5 clock = ~clock;

  led_matrix_scanner #(
    .ROWS(6), .COLS(6), .DWELL_CYCLES(4), .BLANK_CYCLES(1)
  ) dut (
    .clock      (clock),
    .restart    (restart),
    .enable     (enable),
    .frame      (frame),
    .frame_valid(frame_valid),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_done (frame_done),
    .db_row     (db_row),
    .db_state   (db_state)
  );

  assign obs = {row_sel, col_data, frame_done, db_row, db_state};

  function automatic logic [17:0] m_expect();
    int ph, row;
    logic [5:0] rs, cd;
    logic [1:0] st;
    logic fd;
    if (!m_scan) return 18'd0;
    ph = m_tick % RP;
    row = (m_tick / RP) % ROWS;
    rs = '0; cd = '0; fd = 1'b0;
    if (ph < BW) st = 2'd1;
    else if (ph < BW + DW) begin
      st = 2'd2;
      rs = 6'(1 << row);
      cd = 6'(m_active >> (row * COLS));
    end else begin
      st = 2'd3;
      fd = (row == ROWS - 1);
    end
    return {rs, cd, fd, 3'(row), st};
  endfunction

  function automatic logic [FW-1:0] rnd_frame();
    return {4'($urandom), $urandom};
  endfunction

  // Advance one clock edge and update the model with the inputs held across it.
  task automatic cyc();
    bit cm;
    int ph, row;
    @(posedge clock);
    if (restart) begin
      m_scan = 1'b0; m_tick = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0;
    end else begin
      ph  = m_tick % RP;
      row = (m_tick / RP) % ROWS;
      cm  = m_pending && (!m_scan || (ph == RP - 1 && row == ROWS - 1));
      if (m_scan) begin
        if (enable) m_tick++;
        else begin m_scan = 1'b0; m_tick = 0; end
      end else if (enable) begin
        m_scan = 1'b1; m_tick = 0;
      end
      if (cm) begin m_active = m_shadow; m_pending = 1'b0; end
      if (frame_valid) begin m_shadow = frame; m_pending = 1'b1; end
    end
    #1;
  endtask

  task automatic do_reset();
    restart = 1'b1; enable = 1'b0; frame_valid = 1'b0;
    cyc();
    restart = 1'b0;
  endtask

  task automatic load_idle(input logic [FW-1:0] f);
    frame = f; frame_valid = 1'b1;
    cyc();
    frame_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    restart = 1'b1; enable = 1'b1; frame_valid = 1'b1; frame = rnd_frame();
    cyc();
    frame_valid = 1'b0;
    n_run++;
    if (obs !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs, 18'd0);
    end
    restart = 1'b0;
    cyc();
    n_run++;
    if (db_state !== 2'b01 || row_sel !== 6'd0) begin
      n_fail++; $display("FAIL reset_blank got state=%b row_sel=%b exp state=01 row_sel=000000", db_state, row_sel);
    end
    cyc();
    n_run++;
    if (row_sel !== 6'b000001 || col_data !== 6'd0) begin
      n_fail++; $display("FAIL reset_first_drive got row_sel=%b col=%b exp 000001/000000", row_sel, col_data);
    end
    n_run++;
    if (obs !== m_expect()) begin
      n_fail++; $display("FAIL reset_model got=%h exp=%h", obs, m_expect());
    end
  endtask

  task automatic test_single_frame();
    int lit0 = 0, done_cnt = 0, bad = 0, mm = 0;
    do_reset();
    load_idle(36'h0_0000_003F);
    enable = 1'b1;
    for (int i = 0; i < 2 * FP; i++) begin
      cyc();
      if (row_sel === 6'b000001 && col_data === 6'h3F) lit0++;
      if (frame_done === 1'b1) done_cnt++;
      if (row_sel !== 6'b000001 && col_data !== 6'd0) bad++;
      if (obs !== m_expect()) mm++;
    end
    n_run++;
    if (lit0 !== 2 * DW) begin n_fail++; $display("FAIL single_row0_lit got=%0d exp=%0d", lit0, 2 * DW); end
    n_run++;
    if (done_cnt !== 2) begin n_fail++; $display("FAIL single_frame_done got=%0d exp=2", done_cnt); end
    n_run++;
    if (bad !== 0) begin n_fail++; $display("FAIL single_other_rows got=%0d nonzero exp=0", bad); end
    n_run++;
    if (mm !== 0) begin n_fail++; $display("FAIL single_model got=%0d mismatching cycles exp=0", mm); end
  endtask

  task automatic test_no_tearing();
    int ph, row;
    do_reset();
    load_idle(36'h5_5555_5555);
    enable = 1'b1;
    for (int i = 0; i < 2 * FP; i++) begin
      frame_valid = (i == 2 * RP + 2);
      frame = 36'hF_FFFF_FFFF;
      cyc();
      ph = i % RP; row = (i / RP) % ROWS;
      if (ph >= BW && ph < BW + DW && (i >= FP || row >= 3)) begin
        n_run++;
        if (col_data !== ((i < FP) ? 6'h15 : 6'h3F)) begin
          n_fail++; $display("FAIL tearing t=%0d row=%0d got=%h exp=%h", i, row, col_data, (i < FP) ? 6'h15 : 6'h3F);
        end
      end
      n_run++;
      if (obs !== m_expect()) begin n_fail++; $display("FAIL tearing_model t=%0d got=%h exp=%h", i, obs, m_expect()); end
    end
    frame_valid = 1'b0;
  endtask

  task automatic test_commit_collision();
    logic [FW-1:0] p, q, c, want;
    int ph, row;
    p = rnd_frame(); q = rnd_frame(); c = rnd_frame();
    do_reset();
    load_idle(p);
    enable = 1'b1;
    for (int i = 0; i < 3 * FP; i++) begin
      frame_valid = (i == 10) || (i == FP);
      frame = (i == FP) ? c : q;
      cyc();
      ph = i % RP; row = (i / RP) % ROWS;
      want = (i < FP) ? p : ((i < 2 * FP) ? q : c);
      if (ph >= BW && ph < BW + DW) begin
        n_run++;
        if (col_data !== 6'(want >> (row * COLS))) begin
          n_fail++; $display("FAIL collision t=%0d row=%0d got=%h exp=%h", i, row, col_data, 6'(want >> (row * COLS)));
        end
      end
    end
    frame_valid = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic [FW-1:0] n;
    int i;
    n = rnd_frame();
    do_reset();
    load_idle(rnd_frame());
    enable = 1'b1;
    for (i = 0; i <= 3 * RP + 2; i++) begin
      frame_valid = (i == 5);
      frame = n;
      if (i == 3 * RP + 2) enable = 1'b0;
      cyc();
    end
    frame_valid = 1'b0;
    n_run++;
    if (obs !== 18'd0) begin n_fail++; $display("FAIL enable_drop got=%h exp=%h", obs, 18'd0); end
    cyc(); cyc();
    enable = 1'b1;
    cyc();
    n_run++;
    if (db_state !== 2'b01 || db_row !== 3'd0 || row_sel !== 6'd0) begin
      n_fail++; $display("FAIL reenable_blank got state=%b row=%0d sel=%b exp 01/0/000000", db_state, db_row, row_sel);
    end
    cyc();
    n_run++;
    if (row_sel !== 6'b000001 || col_data !== n[5:0]) begin
      n_fail++; $display("FAIL reenable_row0 got sel=%b col=%h exp 000001/%h", row_sel, col_data, n[5:0]);
    end
    n_run++;
    if (obs !== m_expect()) begin n_fail++; $display("FAIL enable_model got=%h exp=%h", obs, m_expect()); end
  endtask

  task automatic test_restart_mid();
    int nz = 0;
    do_reset();
    load_idle(36'hF_FFFF_FFFF);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      frame_valid = (i == 3);
      frame = rnd_frame();
      restart = (i == 7);
      cyc();
    end
    frame_valid = 1'b0;
    restart = 1'b0;
    n_run++;
    if (obs !== 18'd0) begin n_fail++; $display("FAIL restart_mid got=%h exp=%h", obs, 18'd0); end
    for (int i = 0; i < FP + 1; i++) begin
      cyc();
      if (col_data !== 6'd0) nz++;
    end
    n_run++;
    if (nz !== 0) begin n_fail++; $display("FAIL restart_cleared got=%0d lit cycles exp=0", nz); end
    n_run++;
    if (obs !== m_expect()) begin n_fail++; $display("FAIL restart_model got=%h exp=%h", obs, m_expect()); end
  endtask

  task automatic test_random();
    int mm = 0;
    for (int i = 0; i < 3000; i++) begin
      restart     = ($urandom_range(0, 299) == 0);
      enable      = ($urandom_range(0, 59) != 0);
      frame_valid = ($urandom_range(0, 14) == 0);
      frame       = rnd_frame();
      cyc();
      n_run++;
      if (obs !== m_expect()) begin
        n_fail++; mm++;
        if (mm <= 10) $display("FAIL random t=%0d got=%h exp=%h", i, obs, m_expect());
      end
    end
    restart = 1'b0; frame_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_no_tearing();
    test_commit_collision();
    test_enable_drop();
    test_restart_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
